// File: rtl/pc_sequencer.sv
// Program-counter sequencer: hold / increment / conditional jump with a post-jump flush window.
// Optional return-address stack is compiled in with `define PC_SEQUENCER_RAS_EN.
module pc_sequencer #(
   parameter int unsigned           PC_WIDTH     = 16,
   parameter int unsigned           PC_STEP      = 2,
   parameter logic [PC_WIDTH-1:0]   RESET_PC     = '0,
   parameter int unsigned           FLUSH_CYCLES = 2,
   parameter int unsigned           RAS_DEPTH    = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                stall,
   input  logic                pc_write,
   input  logic                jump,
   input  logic [1:0]          jump_cond,
   input  logic                isZero,
   input  logic                isNeg,
   input  logic [PC_WIDTH-1:0] jump_target,
   input  logic                call,
   input  logic                ret,
   output logic [PC_WIDTH-1:0] pc,
   output logic                pc_enable,
   output logic                taken,
   output logic                flush,
   output logic                ras_err
);

   localparam logic [PC_WIDTH-1:0] STEP       = PC_WIDTH'(PC_STEP);
   localparam logic [3:0]          FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

   typedef enum logic {S_IDLE, S_FLUSH} state_e;

   state_e              state_q, state_d;
   logic [3:0]          fcnt_q, fcnt_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic                taken_q;
   logic                cond_ok, jump_go;
   logic [PC_WIDTH-1:0] target;

   always_comb begin
      case (jump_cond)
         2'b00:   cond_ok = 1'b1;
         2'b01:   cond_ok = isZero;
         2'b10:   cond_ok = !isZero;
         default: cond_ok = isNeg;
      endcase
   end

   assign flush = (state_q == S_FLUSH);

`ifdef PC_SEQUENCER_RAS_EN
   localparam int AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CW = $clog2(RAS_DEPTH + 1);

   logic [PC_WIDTH-1:0] ras_q [RAS_DEPTH];
   logic [AW-1:0]       top_q, top_inc, top_dec;   // top_q = next free slot (circular)
   logic [CW-1:0]       cnt_q;
   logic                err_q, ret_go, push, ras_empty;

   assign ret_go    = ret & !flush & !stall;
   assign jump_go   = ((jump & cond_ok) | ret) & !flush & !stall;
   assign push      = jump_go & call & !ret;
   assign ras_empty = (cnt_q == '0);
   assign top_inc   = (top_q == AW'(RAS_DEPTH - 1)) ? '0 : top_q + 1'b1;
   assign top_dec   = (top_q == '0) ? AW'(RAS_DEPTH - 1) : top_q - 1'b1;
   assign target    = ret ? (ras_empty ? RESET_PC : ras_q[top_dec]) : jump_target;
   assign ras_err   = err_q;

   // Circular buffer: a push when full overwrites the oldest slot.
   always_ff @(posedge clk) begin
      if (push) ras_q[top_q] <= pc_q + STEP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         top_q <= '0;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (ret_go) begin
         if (ras_empty) begin
            err_q <= 1'b1;
         end else begin
            top_q <= top_dec;
            cnt_q <= cnt_q - 1'b1;
         end
      end else if (push) begin
         top_q <= top_inc;
         if (cnt_q == CW'(RAS_DEPTH)) err_q <= 1'b1;
         else                         cnt_q <= cnt_q + 1'b1;
      end
   end
`else
   logic unused_ras;
   assign unused_ras = ^{call, ret};
   assign jump_go    = jump & cond_ok & !flush & !stall;
   assign target     = jump_target;
   assign ras_err    = 1'b0;
`endif

   assign pc_enable = !stall & (pc_write | jump_go);
   assign pc        = pc_q;
   assign taken     = taken_q;

   always_comb begin
      pc_d    = pc_q;
      state_d = state_q;
      fcnt_d  = fcnt_q;
      if (jump_go) begin
         pc_d    = target;
         state_d = S_FLUSH;
         fcnt_d  = FLUSH_INIT;
      end else if (!stall) begin
         if (pc_write) pc_d = pc_q + STEP;
         if (state_q == S_FLUSH) begin
            if (fcnt_q == '0) state_d = S_IDLE;
            else              fcnt_d  = fcnt_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q    <= RESET_PC;
         state_q <= S_IDLE;
         fcnt_q  <= '0;
         taken_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         taken_q <= jump_go;
      end
   end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with default parameters; RAS vectors run when the macro is defined.
module tb_pc_sequencer;
   logic        clk = 1'b0;
   logic        rst_n, stall, pc_write, jump, isZero, isNeg, call, ret;
   logic [1:0]  jump_cond;
   logic [15:0] jump_target, pc;
   logic        pc_enable, taken, flush, ras_err;
   int          checks = 0, errors = 0;

   pc_sequencer dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .pc_write(pc_write), .jump(jump),
      .jump_cond(jump_cond), .isZero(isZero), .isNeg(isNeg), .jump_target(jump_target),
      .call(call), .ret(ret), .pc(pc), .pc_enable(pc_enable), .taken(taken),
      .flush(flush), .ras_err(ras_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic jmp(input logic [1:0] c, input logic [15:0] t);
      jump = 1'b1; jump_cond = c; jump_target = t;
   endtask

   task automatic idle();
      jump = 1'b0; pc_write = 1'b0; call = 1'b0; ret = 1'b0; stall = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; stall = 1'b0; pc_write = 1'b0; jump = 1'b0; jump_cond = 2'b00;
      isZero = 1'b0; isNeg = 1'b0; jump_target = '0; call = 1'b0; ret = 1'b0;
      #3;
      chk("rst_pc", pc, 0); chk("rst_taken", taken, 0); chk("rst_flush", flush, 0);
      chk("rst_ras_err", ras_err, 0);
      step(2); #2 rst_n = 1'b1;

      // sequential advance
      pc_write = 1'b1; #1;
      chk("seq_en", pc_enable, 1);
      step(); chk("seq_pc1", pc, 16'h0002);
      step(); chk("seq_pc2", pc, 16'h0004);
      step(); chk("seq_pc3", pc, 16'h0006);
      chk("seq_taken", taken, 0); chk("seq_flush", flush, 0);

      // taken jump on isZero
      pc_write = 1'b0; isZero = 1'b1; jmp(2'b01, 16'h0040); #1;
      chk("jz_en", pc_enable, 1);
      step(); idle();
      chk("jz_pc", pc, 16'h0040); chk("jz_taken", taken, 1); chk("jz_flush1", flush, 1);
      step(); chk("jz_taken_pulse", taken, 0); chk("jz_flush2", flush, 1);
      step(); chk("jz_flush_end", flush, 0);

      // condition false with pc_write -> plain increment
      jmp(2'b10, 16'h0100); pc_write = 1'b1; #1;
      chk("nz_false_en", pc_enable, 1);
      step(); idle();
      chk("nz_false_pc", pc, 16'h0042); chk("nz_false_taken", taken, 0);

      // condition false, no pc_write -> hold
      isNeg = 1'b0; jmp(2'b11, 16'h0100); #1;
      chk("neg_false_en", pc_enable, 0);
      step(); idle(); chk("neg_false_pc", pc, 16'h0042);

      // jump inside flush window is dropped, pc_write still advances
      jmp(2'b00, 16'h0080); step();
      chk("j2_pc", pc, 16'h0080);
      jmp(2'b00, 16'h0100); pc_write = 1'b1;
      step(); chk("drop_pc1", pc, 16'h0082); chk("drop_taken", taken, 0);
      step(); chk("drop_pc2", pc, 16'h0084); chk("drop_flush", flush, 0);
      idle();

      // wrap-around
      jmp(2'b00, 16'hFFFE); step(); idle();
      pc_write = 1'b1; step(); chk("wrap_pc", pc, 16'h0000);
      idle();
      step(); chk("wrap_hold", pc, 16'h0000);

      // stall mid-flush
      isNeg = 1'b1; jmp(2'b11, 16'h0040); step(); idle();
      chk("stall_jpc", pc, 16'h0040);
      stall = 1'b1; pc_write = 1'b1; jump = 1'b1; #1;
      chk("stall_en", pc_enable, 0);
      step(3);
      chk("stall_pc", pc, 16'h0040); chk("stall_flush", flush, 1); chk("stall_taken", taken, 0);
      idle();
      step(); chk("stall_flush_a", flush, 1);
      step(); chk("stall_flush_b", flush, 0);

      // async reset mid-flush
      jmp(2'b00, 16'h0050); step(); idle();
      chk("ar_flush_pre", flush, 1);
      #2 rst_n = 1'b0; #1;
      chk("ar_pc", pc, 16'h0000); chk("ar_flush", flush, 0); chk("ar_taken", taken, 0);
      #1 rst_n = 1'b1;
      step(); chk("ar_after", flush, 0);

`ifdef PC_SEQUENCER_RAS_EN
      jmp(2'b00, 16'h0010); step(); idle(); step(2);
      call = 1'b1; jmp(2'b00, 16'h0100); step(); idle();
      chk("ras_call_pc", pc, 16'h0100); step(2);
      ret = 1'b1; jump_target = 16'h0BAD; #1;
      chk("ras_ret_en", pc_enable, 1);
      step(); idle(); chk("ras_ret_pc", pc, 16'h0012); step(2);
      for (int i = 0; i < 5; i++) begin
         call = 1'b1; jmp(2'b00, 16'h0200); step(); idle(); step(2);
         if (i == 3) chk("ras_no_err4", ras_err, 0);
      end
      chk("ras_ovf_err", ras_err, 1);
      rst_n = 1'b0; #1 rst_n = 1'b1;
      chk("ras_err_clr", ras_err, 0);
      step(); jmp(2'b00, 16'h0030); step(); idle(); step(2);
      ret = 1'b1; step(); idle();
      chk("ras_empty_pc", pc, 16'h0000); chk("ras_unf_err", ras_err, 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
